// File: rtl/tx_frame_fifo.sv
// Store-and-forward byte FIFO feeding the GMII transmit engine. A frame becomes
// visible on fifo_rd_* only after its last byte is committed; overflowing or aborted frames are dropped and counted.
module tx_frame_fifo #(
  parameter int ADDR_W     = 11,
  parameter int DROP_CNT_W = 16
) (
  input  logic                  gmii_tx_clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [7:0]            wr_data,
  input  logic                  wr_last,
  input  logic                  wr_abort,
  output logic                  fifo_rd_valid,
  input  logic                  fifo_rd_ready,
  output logic [7:0]            fifo_rd_data,
  output logic                  fifo_rd_last,
  output logic [ADDR_W:0]       frame_cnt,
  output logic                  drop_pulse,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int PTR_W = ADDR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] DEPTH_PTR = {1'b1, {ADDR_W{1'b0}}};

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + {{(DROP_CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic [8:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, commit_ptr, rd_ptr;
  logic             dropping;
  logic             wr_ready_q;
  logic             vld_p1;
  logic [7:0]       data_p1;
  logic             last_p1;

  logic full, wr_acc, in_progress, abort_evt, drop_now;
  logic store, commit, ovf_end, drop_evt, pop, pop_last, fetch;
  logic [PTR_W-1:0] wr_ptr_nxt;

  always_comb begin
    full        = (wr_ptr - rd_ptr) == DEPTH_PTR;
    wr_acc      = wr_valid && wr_ready_q;
    in_progress = (wr_ptr != commit_ptr) || dropping;
    abort_evt   = wr_abort && in_progress;
    drop_now    = dropping || full;
    store       = wr_acc && !wr_abort && !drop_now;
    commit      = store && wr_last;
    // A frame that ran out of room ends on its last byte; only then is it counted.
    ovf_end     = wr_acc && !wr_abort && drop_now && wr_last;
    drop_evt    = abort_evt || ovf_end;
    wr_ptr_nxt  = wr_ptr + PTR_ONE;
    pop         = vld_p1 && fifo_rd_ready;
    pop_last    = pop && last_p1;
    // Only committed bytes are fetched; the output register refills as it drains.
    fetch       = (rd_ptr != commit_ptr) && (!vld_p1 || fifo_rd_ready);
  end

  // Stage p0: write port into the frame RAM
  always_ff @(posedge gmii_tx_clk) begin
    if (store) mem[wr_ptr[ADDR_W-1:0]] <= {wr_last, wr_data};
  end

  // Write-side control: pointers, dropping flag, drop statistics
  always_ff @(posedge gmii_tx_clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      dropping   <= 1'b0;
      wr_ready_q <= 1'b0;
      drop_pulse <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      wr_ready_q <= 1'b1;
      if (wr_abort) begin
        wr_ptr   <= commit_ptr;
        dropping <= 1'b0;
      end else if (wr_acc) begin
        if (drop_now) begin
          if (wr_last) begin
            wr_ptr   <= commit_ptr;
            dropping <= 1'b0;
          end else begin
            dropping <= 1'b1;
          end
        end else begin
          wr_ptr <= wr_ptr_nxt;
          if (wr_last) commit_ptr <= wr_ptr_nxt;
        end
      end
      drop_pulse <= drop_evt;
      if (drop_evt) drop_cnt <= sat_inc(drop_cnt);
    end
  end

  // Stage p1: synchronous RAM read lands directly in the output register
  always_ff @(posedge gmii_tx_clk) begin
    if (rst) begin
      rd_ptr  <= '0;
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      last_p1 <= 1'b0;
    end else begin
      if (fetch) begin
        rd_ptr            <= rd_ptr + PTR_ONE;
        vld_p1            <= 1'b1;
        {last_p1, data_p1} <= mem[rd_ptr[ADDR_W-1:0]];
      end else if (pop) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  always_ff @(posedge gmii_tx_clk) begin
    if (rst) begin
      frame_cnt <= '0;
    end else begin
      case ({commit, pop_last})
        2'b10:   frame_cnt <= frame_cnt + {{ADDR_W{1'b0}}, 1'b1};
        2'b01:   frame_cnt <= frame_cnt - {{ADDR_W{1'b0}}, 1'b1};
        default: frame_cnt <= frame_cnt;
      endcase
    end
  end

  assign wr_ready      = wr_ready_q;
  assign fifo_rd_valid = vld_p1;
  assign fifo_rd_data  = data_p1;
  assign fifo_rd_last  = last_p1;

endmodule

// File: tb/tb_tx_frame_fifo.sv
// Scoreboard bench for tx_frame_fifo: the writer pushes committed frames into an
// expected byte queue, and an independent monitor pops and compares every delivered byte.
module tb_tx_frame_fifo;

  localparam int ADDR_W     = 6;
  localparam int DEPTH      = 1 << ADDR_W;
  localparam int DROP_CNT_W = 16;

  logic                  gmii_tx_clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  wr_valid = 1'b0;
  logic                  wr_ready;
  logic [7:0]            wr_data = '0;
  logic                  wr_last = 1'b0;
  logic                  wr_abort = 1'b0;
  logic                  fifo_rd_valid;
  logic                  fifo_rd_ready = 1'b0;
  logic [7:0]            fifo_rd_data;
  logic                  fifo_rd_last;
  logic [ADDR_W:0]       frame_cnt;
  logic                  drop_pulse;
  logic [DROP_CNT_W-1:0] drop_cnt;

  tx_frame_fifo #(.ADDR_W(ADDR_W), .DROP_CNT_W(DROP_CNT_W)) dut (
    .gmii_tx_clk  (gmii_tx_clk),
    .rst          (rst),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_data      (wr_data),
    .wr_last      (wr_last),
    .wr_abort     (wr_abort),
    .fifo_rd_valid(fifo_rd_valid),
    .fifo_rd_ready(fifo_rd_ready),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_last (fifo_rd_last),
    .frame_cnt    (frame_cnt),
    .drop_pulse   (drop_pulse),
    .drop_cnt     (drop_cnt)
  );

  always #5 gmii_tx_clk = ~gmii_tx_clk;

  int         checks = 0;
  int         errors = 0;
  logic [8:0] exp_q[$];
  logic [7:0] frm[$];
  int         committed = 0;
  int         last_pops = 0;
  int         exp_drops = 0;
  int         pulses = 0;
  bit         mon_en = 1'b0;
  int         rdy_mode = 0;
  bit         rdy_fixed = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Consumer ready: fixed, random, or toggling every cycle
  initial begin
    forever begin
      @(posedge gmii_tx_clk);
      #1;
      case (rdy_mode)
        0:       fifo_rd_ready = rdy_fixed;
        1:       fifo_rd_ready = ($urandom_range(0, 99) < 60);
        default: fifo_rd_ready = ~fifo_rd_ready;
      endcase
    end
  end

  // Monitor: frames held = committed minus fully delivered; bytes in order; stall stability
  initial begin
    logic       prev_v = 1'b0, prev_r = 1'b0, prev_rst = 1'b1;
    logic [8:0] prev_d = '0;
    logic [8:0] e;
    forever begin
      @(negedge gmii_tx_clk);
      if (mon_en) begin
        if (!prev_rst && prev_v && !prev_r) begin
          check("hold_valid", fifo_rd_valid, 1);
          check("hold_data", {fifo_rd_last, fifo_rd_data}, prev_d);
        end
        check("frame_cnt", frame_cnt, committed - last_pops);
        if (drop_pulse) pulses++;
        if (fifo_rd_valid && fifo_rd_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte got=%0h want=none", {fifo_rd_last, fifo_rd_data});
          end else begin
            e = exp_q.pop_front();
            check("rd_byte", {fifo_rd_last, fifo_rd_data}, e);
            if (e[8]) last_pops++;
          end
        end
      end
      prev_v   = fifo_rd_valid;
      prev_r   = fifo_rd_ready;
      prev_d   = {fifo_rd_last, fifo_rd_data};
      prev_rst = rst;
    end
  end

  task automatic write_byte(input logic [7:0] d, input logic l, input logic ab);
    wr_valid = 1'b1;
    wr_data  = d;
    wr_last  = l;
    wr_abort = ab;
    @(posedge gmii_tx_clk);
    #1;
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    wr_abort = 1'b0;
  endtask

  task automatic push_frame();
    for (int i = 0; i < frm.size(); i++) exp_q.push_back({(i == frm.size() - 1), frm[i]});
    committed++;
  endtask

  task automatic build_ramp(input int len, input int base);
    frm = {};
    for (int i = 0; i < len; i++) frm.push_back(8'(base + i));
  endtask

  task automatic build_rand(input int len);
    frm = {};
    for (int i = 0; i < len; i++) frm.push_back(8'($urandom));
  endtask

  // Sends frm; abort_idx >= 0 pulses wr_abort together with that byte
  task automatic send_frame(input int abort_idx, input int gap_pct);
    for (int i = 0; i < frm.size(); i++) begin
      if ($urandom_range(0, 99) < gap_pct) begin
        @(posedge gmii_tx_clk);
        #1;
      end
      if (i == abort_idx) begin
        write_byte(frm[i], (i == frm.size() - 1), 1'b1);
        break;
      end
      write_byte(frm[i], (i == frm.size() - 1), 1'b0);
    end
    if (abort_idx >= 0) begin
      if (abort_idx > 0) exp_drops++;
    end else if (frm.size() > DEPTH) begin
      exp_drops++;
    end else begin
      push_frame();
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge gmii_tx_clk);
      n++;
    end
    check(name, exp_q.size(), 0);
    repeat (3) @(negedge gmii_tx_clk);
  endtask

  task automatic wait_space(input int len);
    int n = 0;
    while (exp_q.size() + len > DEPTH && n < 3000) begin
      @(negedge gmii_tx_clk);
      n++;
    end
    check("space_wait", (exp_q.size() + len > DEPTH), 0);
    @(posedge gmii_tx_clk);
    #1;
  endtask

  task automatic set_ready(input int mode, input bit val);
    rdy_mode  = mode;
    rdy_fixed = val;
    @(posedge gmii_tx_clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int bad;
    int n;
    // Reset values
    repeat (3) @(posedge gmii_tx_clk);
    @(negedge gmii_tx_clk);
    check("rst_valid", fifo_rd_valid, 0);
    check("rst_data", fifo_rd_data, 0);
    check("rst_last", fifo_rd_last, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_drop_pulse", drop_pulse, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_wr_ready", wr_ready, 0);
    @(posedge gmii_tx_clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    @(posedge gmii_tx_clk);
    @(negedge gmii_tx_clk);
    check("wr_ready_up", wr_ready, 1);

    // 64-byte ramp, exactly filling the buffer; valid rises two cycles after last
    set_ready(0, 1'b1);
    build_ramp(64, 0);
    send_frame(-1, 0);
    @(negedge gmii_tx_clk);
    check("lat_cycle1", fifo_rd_valid, 0);
    @(negedge gmii_tx_clk);
    check("lat_cycle2", fifo_rd_valid, 1);
    drain("t1_drain");

    // Uncommitted bytes never leak out
    build_ramp(11, 8'h80);
    for (int i = 0; i < 10; i++) write_byte(frm[i], 1'b0, 1'b0);
    bad = 0;
    repeat (20) begin
      @(negedge gmii_tx_clk);
      if (fifo_rd_valid) bad++;
    end
    check("no_early_valid", bad, 0);
    @(posedge gmii_tx_clk);
    #1;
    write_byte(frm[10], 1'b1, 1'b0);
    push_frame();
    drain("t2_drain");

    // Overlong frame with consumer stalled: dropped, then a short frame goes through
    set_ready(0, 1'b0);
    build_ramp(80, 8'h10);
    send_frame(-1, 0);
    repeat (3) @(negedge gmii_tx_clk);
    check("ovf_no_output", fifo_rd_valid, 0);
    check("ovf_pulses", pulses, exp_drops);
    check("ovf_drop_cnt", drop_cnt, exp_drops);
    build_ramp(8, 8'hC0);
    send_frame(-1, 0);
    set_ready(0, 1'b1);
    drain("t3_drain");

    // Abort on byte 6 (also flagged last): abort wins, nothing committed
    build_ramp(6, 8'h50);
    send_frame(5, 0);
    repeat (3) @(negedge gmii_tx_clk);
    check("abort_no_output", fifo_rd_valid, 0);
    check("abort_drop_cnt", drop_cnt, exp_drops);
    check("abort_pulses", pulses, exp_drops);
    build_ramp(3, 8'hA1);
    send_frame(-1, 0);
    drain("t4_drain");

    // Frame pairs under toggling ready, sweeping the inter-frame gap
    set_ready(2, 1'b0);
    for (int g = 0; g < 8; g++) begin
      build_ramp(4, 8'h20 + 8 * g);
      send_frame(-1, 0);
      repeat (g) begin
        @(posedge gmii_tx_clk);
        #1;
      end
      build_ramp(4, 8'h24 + 8 * g);
      send_frame(-1, 0);
      drain("t5_drain");
    end

    // Reset mid-read with a second frame committed
    build_rand(20);
    send_frame(-1, 0);
    build_rand(5);
    send_frame(-1, 0);
    n = 0;
    while (exp_q.size() > 20 && n < 200) begin
      @(negedge gmii_tx_clk);
      n++;
    end
    check("t6_mid_read", (exp_q.size() > 5 && exp_q.size() <= 20), 1);
    @(posedge gmii_tx_clk);
    #1;
    rst = 1'b1;
    @(posedge gmii_tx_clk);
    #1;
    exp_q.delete();
    committed = 0;
    last_pops = 0;
    exp_drops = 0;
    pulses    = 0;
    @(negedge gmii_tx_clk);
    check("t6_rst_valid", fifo_rd_valid, 0);
    check("t6_rst_frame_cnt", frame_cnt, 0);
    check("t6_rst_drop_cnt", drop_cnt, 0);
    @(posedge gmii_tx_clk);
    #1;
    rst = 1'b0;
    set_ready(0, 1'b1);
    @(posedge gmii_tx_clk);
    #1;
    build_rand(60);
    send_frame(-1, 0);
    drain("t6_drain");

    // Randomized traffic: normal, overlong and aborted frames, random ready and gaps
    set_ready(1, 1'b0);
    for (int f = 0; f < 120; f++) begin
      int kind, len, ab;
      kind = int'($urandom_range(0, 9));
      ab   = -1;
      if (kind == 0) begin
        len = int'($urandom_range(65, 80));
      end else if (kind == 1) begin
        len = int'($urandom_range(2, 16));
        ab  = int'($urandom_range(0, len - 1));
        wait_space(len);
      end else begin
        len = int'($urandom_range(1, 24));
        wait_space(len);
      end
      build_rand(len);
      send_frame(ab, 20);
    end
    drain("rand_drain");
    check("rand_pulses", pulses, exp_drops);
    check("rand_drop_cnt", drop_cnt, exp_drops);
    check("rand_frame_cnt", frame_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_frame_fifo.md
Name: tx_frame_fifo

Overview:
- Single-clock store-and-forward frame buffer in the gmii_tx_clk domain, directly upstream of the GMII transmit engine; drives its fifo_rd_* interface.
- Accepts byte-wide frames (data plus last flag) from the MAC host side and commits each frame only when its last byte is written.
- Exposes a frame downstream only once the whole frame is committed, so the transmit engine never underruns mid-frame.
- Drops frames that overflow the buffer or are aborted by the writer, and counts the drops.

Parameters:
- ADDR_W, 11, log2 of buffer depth in bytes (DEPTH = 2^ADDR_W); legal range 4..14.
- DROP_CNT_W, 16, width of the saturating dropped-frame counter.

Ports:
- gmii_tx_clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- wr_valid  in  1  write byte valid.
- wr_ready  out  1  write ready; always 1 outside reset (overflow is handled by dropping, not by back-pressure).
- wr_data  in  8  write byte.
- wr_last  in  1  final byte of the frame.
- wr_abort  in  1  single-cycle pulse; discards the frame currently being written.
- fifo_rd_valid  out  1  read byte valid (first-word-fall-through).
- fifo_rd_ready  in  1  consumer ready.
- fifo_rd_data  out  8  read byte.
- fifo_rd_last  out  1  read byte is the frame's last.
- frame_cnt  out  ADDR_W+1  committed frames not yet fully read.
- drop_pulse  out  1  one-cycle pulse per dropped frame.
- drop_cnt  out  DROP_CNT_W  saturating count of dropped frames.

Behaviour:
- Clocking and reset: one clock, gmii_tx_clk; reset is synchronous and active-high (rst).
  - On rst: all pointers zero, dropping flag clear, output register empty.
  - Output reset values: fifo_rd_valid=0, fifo_rd_data=0, fifo_rd_last=0, frame_cnt=0, drop_pulse=0, drop_cnt=0, wr_ready=0.
  - wr_ready is 1 from the first cycle after rst deasserts.
- Storage: DEPTH x 9-bit RAM holding {last, data}, read synchronously.
  - Pointers are ADDR_W+1 bits: wr_ptr, commit_ptr, rd_ptr.
  - Buffer is full when wr_ptr - rd_ptr == DEPTH (mod 2^(ADDR_W+1)).
- Write accept: wr_valid && wr_ready.
  - Not dropping and not full: store the byte at wr_ptr, wr_ptr += 1.
  - If that byte has wr_last=1: commit_ptr <= new wr_ptr and frame_cnt += 1.
- Overflow: a write accepted while full sets the dropping flag and discards the byte.
  - While dropping, all further bytes are discarded.
  - On the accepted wr_last byte: wr_ptr <= commit_ptr, dropping clears, drop_pulse=1 next cycle, drop_cnt += 1 (saturating).
- Abort: wr_abort=1 sets wr_ptr <= commit_ptr, clears dropping, and pulses drop_pulse/drop_cnt the next cycle.
  - Any write in the same cycle is discarded, including a wr_last byte (abort wins, no commit).
  - wr_abort with no frame in progress (wr_ptr == commit_ptr and not dropping) is a no-op with no pulse.
- Read side: bytes are readable only while rd_ptr != commit_ptr; uncommitted bytes are never fetched.
  - A one-entry output register (with prefetch/skid as needed) presents fifo_rd_data/fifo_rd_last.
  - fifo_rd_valid holds steady until fifo_rd_ready is seen.
  - Data and last never change while valid=1 and ready=0.
- Read latency: with the output empty, fifo_rd_valid rises exactly 2 cycles after the cycle in which wr_last was accepted.
- Throughput: sustained 1 byte/cycle on both sides with fifo_rd_ready held high, with no bubbles inside a frame.
- Frame boundaries: consecutive frames may stream back-to-back.
  - A pop with fifo_rd_last=1 decrements frame_cnt.
  - A commit and a last-pop in the same cycle leave frame_cnt unchanged.
- Space accounting: space is freed when a byte leaves the RAM into the output register.
  - A frame longer than DEPTH always drops.
- Pointer wrap: pointers wrap modulo 2^(ADDR_W+1) with no special handling.
- Status bits: fifo_rd_valid=1 implies frame_cnt >= 1.
  - drop_cnt holds at all-ones once saturated.

Test Plan:
- 64-byte frame, ramp 0x00..0x3F, fifo_rd_ready=1 -> fifo_rd_valid rises 2 cycles after wr_last; 64 consecutive bytes out, last only on 0x3F; frame_cnt goes 0→1→0.
- Write 10 bytes with wr_last=0 and fifo_rd_ready=1, then stall 20 cycles -> fifo_rd_valid stays 0 throughout; after wr_last on byte 11, all 11 bytes are delivered.
- ADDR_W=4, fifo_rd_ready=0; write a 20-byte frame -> no output, one drop_pulse after last, drop_cnt=1; then an 8-byte frame with ready=1 -> exactly those 8 bytes out.
- Write 5 bytes, pulse wr_abort with byte 6 -> drop_cnt=1 and nothing output; next 3-byte frame {A1,A2,A3} -> output A1,A2,A3.
- Two 4-byte frames, ready toggling 1010…, frame 2 committed in the same cycle as frame 1's last pop -> frame_cnt unchanged that cycle; 8 bytes in order; data stable while stalled.
- Assert rst while frame 1 is mid-read and frame 2 is committed -> next cycle fifo_rd_valid=0 and frame_cnt=0; a new 60-byte frame is then delivered intact.
